// File: rtl/axil_arbiter_pkg.sv
// rtl/axil_arbiter_pkg.sv - shared types and constants for the 2:1 AXI-Lite arbiter
package axil_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester round-robin grant selection
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // On contention the requester that did not win last time takes the grant
  always_comb begin
    grant = 1'b0;
    valid = |req;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/axil_arbiter_2to1.sv
// rtl/axil_arbiter_2to1.sv - round-robin 2:1 AXI-Lite arbiter, one transaction in flight
module axil_arbiter_2to1 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                      axi_aclk,
  input  logic                      axi_areset,
  input  logic [ADDR_WIDTH-1:0]     s0_axi_awaddr,
  input  logic                      s0_axi_awvalid,
  output logic                      s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_axi_wstrb,
  input  logic                      s0_axi_wvalid,
  output logic                      s0_axi_wready,
  output logic [1:0]                s0_axi_bresp,
  output logic                      s0_axi_bvalid,
  input  logic                      s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s0_axi_araddr,
  input  logic                      s0_axi_arvalid,
  output logic                      s0_axi_arready,
  output logic [DATA_WIDTH-1:0]     s0_axi_rdata,
  output logic [1:0]                s0_axi_rresp,
  output logic                      s0_axi_rvalid,
  input  logic                      s0_axi_rready,
  input  logic [ADDR_WIDTH-1:0]     s1_axi_awaddr,
  input  logic                      s1_axi_awvalid,
  output logic                      s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_axi_wstrb,
  input  logic                      s1_axi_wvalid,
  output logic                      s1_axi_wready,
  output logic [1:0]                s1_axi_bresp,
  output logic                      s1_axi_bvalid,
  input  logic                      s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s1_axi_araddr,
  input  logic                      s1_axi_arvalid,
  output logic                      s1_axi_arready,
  output logic [DATA_WIDTH-1:0]     s1_axi_rdata,
  output logic [1:0]                s1_axi_rresp,
  output logic                      s1_axi_rvalid,
  input  logic                      s1_axi_rready,
  output logic [ADDR_WIDTH-1:0]     m0_axi_awaddr,
  output logic                      m0_axi_awvalid,
  input  logic                      m0_axi_awready,
  output logic [DATA_WIDTH-1:0]     m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m0_axi_wstrb,
  output logic                      m0_axi_wvalid,
  input  logic                      m0_axi_wready,
  input  logic [1:0]                m0_axi_bresp,
  input  logic                      m0_axi_bvalid,
  output logic                      m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m0_axi_araddr,
  output logic                      m0_axi_arvalid,
  input  logic                      m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m0_axi_rdata,
  input  logic [1:0]                m0_axi_rresp,
  input  logic                      m0_axi_rvalid,
  output logic                      m0_axi_rready,
  output logic                      grant_id,
  output logic                      busy
);
  import axil_arbiter_pkg::*;

  arb_state_t state_q, state_d;
  logic       grant_q, last_grant_q;
  logic       aw_done_q, w_done_q, aw_done_d, w_done_d;
  logic [1:0] req;
  logic       arb_grant, arb_valid, win_awvalid;
  logic       fwd_aw, fwd_w, fwd_b, fwd_ar, fwd_r, to_s0, to_s1;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign req = {s1_axi_awvalid | s1_axi_arvalid, s0_axi_awvalid | s0_axi_arvalid};

  rr_arbiter2 u_rr (
    .req        (req),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  assign win_awvalid = arb_grant ? s1_axi_awvalid : s0_axi_awvalid;

  // Channel forwarding enables derived purely from registered state
  assign fwd_aw = (state_q == ST_WR_ADDR) && !aw_done_q;
  assign fwd_w  = (state_q == ST_WR_ADDR) && !w_done_q;
  assign fwd_b  = (state_q == ST_WR_RESP);
  assign fwd_ar = (state_q == ST_RD_ADDR);
  assign fwd_r  = (state_q == ST_RD_DATA);
  assign to_s0  = ~grant_q;
  assign to_s1  = grant_q;

  // Downstream side: granted master's request channels, zeroed when not forwarded
  assign m0_axi_awvalid = fwd_aw & (grant_q ? s1_axi_awvalid : s0_axi_awvalid);
  assign m0_axi_awaddr  = fwd_aw ? (grant_q ? s1_axi_awaddr : s0_axi_awaddr) : '0;
  assign m0_axi_wvalid  = fwd_w & (grant_q ? s1_axi_wvalid : s0_axi_wvalid);
  assign m0_axi_wdata   = fwd_w ? (grant_q ? s1_axi_wdata : s0_axi_wdata) : '0;
  assign m0_axi_wstrb   = fwd_w ? (grant_q ? s1_axi_wstrb : s0_axi_wstrb) : '0;
  assign m0_axi_bready  = fwd_b & (grant_q ? s1_axi_bready : s0_axi_bready);
  assign m0_axi_arvalid = fwd_ar & (grant_q ? s1_axi_arvalid : s0_axi_arvalid);
  assign m0_axi_araddr  = fwd_ar ? (grant_q ? s1_axi_araddr : s0_axi_araddr) : '0;
  assign m0_axi_rready  = fwd_r & (grant_q ? s1_axi_rready : s0_axi_rready);

  // Upstream side: only the granted master ever sees ready/valid/response
  assign s0_axi_awready = fwd_aw & to_s0 & m0_axi_awready;
  assign s0_axi_wready  = fwd_w & to_s0 & m0_axi_wready;
  assign s0_axi_bvalid  = fwd_b & to_s0 & m0_axi_bvalid;
  assign s0_axi_bresp   = (fwd_b & to_s0) ? m0_axi_bresp : '0;
  assign s0_axi_arready = fwd_ar & to_s0 & m0_axi_arready;
  assign s0_axi_rvalid  = fwd_r & to_s0 & m0_axi_rvalid;
  assign s0_axi_rdata   = (fwd_r & to_s0) ? m0_axi_rdata : '0;
  assign s0_axi_rresp   = (fwd_r & to_s0) ? m0_axi_rresp : '0;
  assign s1_axi_awready = fwd_aw & to_s1 & m0_axi_awready;
  assign s1_axi_wready  = fwd_w & to_s1 & m0_axi_wready;
  assign s1_axi_bvalid  = fwd_b & to_s1 & m0_axi_bvalid;
  assign s1_axi_bresp   = (fwd_b & to_s1) ? m0_axi_bresp : '0;
  assign s1_axi_arready = fwd_ar & to_s1 & m0_axi_arready;
  assign s1_axi_rvalid  = fwd_r & to_s1 & m0_axi_rvalid;
  assign s1_axi_rdata   = (fwd_r & to_s1) ? m0_axi_rdata : '0;
  assign s1_axi_rresp   = (fwd_r & to_s1) ? m0_axi_rresp : '0;

  assign aw_hs = m0_axi_awvalid & m0_axi_awready;
  assign w_hs  = m0_axi_wvalid & m0_axi_wready;
  assign b_hs  = m0_axi_bvalid & m0_axi_bready;
  assign ar_hs = m0_axi_arvalid & m0_axi_arready;
  assign r_hs  = m0_axi_rvalid & m0_axi_rready;

  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

  // Next-state logic; AW and W completion tracked independently in any order
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = win_awvalid ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          state_d   = ST_WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      ST_WR_RESP: if (b_hs)  state_d = ST_IDLE;
      ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_hs)  state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // State, grant ownership and handshake flags; last_grant=1 lets master 0 win first
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (state_q == ST_IDLE && arb_valid) begin
        grant_q      <= arb_grant;
        last_grant_q <= arb_grant;
      end
    end
  end

endmodule

// File: tb/tb_axil_arbiter_2to1.sv
// tb/tb_axil_arbiter_2to1.sv - self-checking bench for axil_arbiter_2to1
module tb_axil_arbiter_2to1;

  logic        axi_aclk = 1'b0;
  logic        axi_areset;
  logic [7:0]  s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
  logic        s0_axi_awvalid, s0_axi_awready, s1_axi_awvalid, s1_axi_awready;
  logic [31:0] s0_axi_wdata, s1_axi_wdata;
  logic [3:0]  s0_axi_wstrb, s1_axi_wstrb;
  logic        s0_axi_wvalid, s0_axi_wready, s1_axi_wvalid, s1_axi_wready;
  logic [1:0]  s0_axi_bresp, s1_axi_bresp;
  logic        s0_axi_bvalid, s0_axi_bready, s1_axi_bvalid, s1_axi_bready;
  logic        s0_axi_arvalid, s0_axi_arready, s1_axi_arvalid, s1_axi_arready;
  logic [31:0] s0_axi_rdata, s1_axi_rdata;
  logic [1:0]  s0_axi_rresp, s1_axi_rresp;
  logic        s0_axi_rvalid, s0_axi_rready, s1_axi_rvalid, s1_axi_rready;
  logic [7:0]  m0_axi_awaddr, m0_axi_araddr;
  logic        m0_axi_awvalid, m0_axi_awready, m0_axi_wvalid, m0_axi_wready;
  logic [31:0] m0_axi_wdata, m0_axi_rdata;
  logic [3:0]  m0_axi_wstrb;
  logic [1:0]  m0_axi_bresp, m0_axi_rresp;
  logic        m0_axi_bvalid, m0_axi_bready, m0_axi_arvalid, m0_axi_arready;
  logic        m0_axi_rvalid, m0_axi_rready;
  logic        grant_id, busy;

  int total = 0;
  int bad = 0;

  axil_arbiter_2to1 #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .axi_aclk(axi_aclk), .axi_areset(axi_areset),
    .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wvalid(s0_axi_wvalid),
    .s0_axi_wready(s0_axi_wready), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arvalid(s0_axi_arvalid),
    .s0_axi_arready(s0_axi_arready), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready),
    .s1_axi_awaddr(s1_axi_awaddr), .s1_axi_awvalid(s1_axi_awvalid), .s1_axi_awready(s1_axi_awready),
    .s1_axi_wdata(s1_axi_wdata), .s1_axi_wstrb(s1_axi_wstrb), .s1_axi_wvalid(s1_axi_wvalid),
    .s1_axi_wready(s1_axi_wready), .s1_axi_bresp(s1_axi_bresp), .s1_axi_bvalid(s1_axi_bvalid),
    .s1_axi_bready(s1_axi_bready), .s1_axi_araddr(s1_axi_araddr), .s1_axi_arvalid(s1_axi_arvalid),
    .s1_axi_arready(s1_axi_arready), .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
    .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rready(s1_axi_rready),
    .m0_axi_awaddr(m0_axi_awaddr), .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready),
    .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_wvalid(m0_axi_wvalid),
    .m0_axi_wready(m0_axi_wready), .m0_axi_bresp(m0_axi_bresp), .m0_axi_bvalid(m0_axi_bvalid),
    .m0_axi_bready(m0_axi_bready), .m0_axi_araddr(m0_axi_araddr), .m0_axi_arvalid(m0_axi_arvalid),
    .m0_axi_arready(m0_axi_arready), .m0_axi_rdata(m0_axi_rdata), .m0_axi_rresp(m0_axi_rresp),
    .m0_axi_rvalid(m0_axi_rvalid), .m0_axi_rready(m0_axi_rready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 axi_aclk = ~axi_aclk;

  // Control bit order: s inputs {awvalid,wvalid,bready,arvalid,rready},
  // m0 inputs {awready,wready,bvalid,arready,rvalid}, m0 outputs {awvalid,wvalid,bready,arvalid,rready},
  // s outputs {awready,wready,bvalid,arready,rvalid}
  typedef struct packed {
    logic [4:0]  s0c, s1c, mc;
    logic [31:0] mrdata;
    logic        busy, gid;
    logic [4:0]  m_o, s0_o, s1_o;
    logic [7:0]  awaddr;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [7:0]  araddr;
    logic [31:0] r0, r1;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mkv(input logic [4:0] s0c, s1c, mc, input logic [31:0] mrdata,
                               input logic b, g, input logic [4:0] m_o, s0_o, s1_o,
                               input logic [7:0] awaddr, input logic [31:0] wd, input logic [3:0] ws,
                               input logic [7:0] araddr, input logic [31:0] r0, r1);
    vec_t v;
    v.s0c = s0c; v.s1c = s1c; v.mc = mc; v.mrdata = mrdata; v.busy = b; v.gid = g;
    v.m_o = m_o; v.s0_o = s0_o; v.s1_o = s1_o; v.awaddr = awaddr; v.wd = wd; v.ws = ws;
    v.araddr = araddr; v.r0 = r0; v.r1 = r1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] m);
    {s0_axi_awvalid, s0_axi_wvalid, s0_axi_bready, s0_axi_arvalid, s0_axi_rready} = a;
    {s1_axi_awvalid, s1_axi_wvalid, s1_axi_bready, s1_axi_arvalid, s1_axi_rready} = b;
    {m0_axi_awready, m0_axi_wready, m0_axi_bvalid, m0_axi_arready, m0_axi_rvalid} = m;
  endtask

  function automatic logic [16:0] ctrl_now();
    return {busy, grant_id & busy,
            m0_axi_awvalid, m0_axi_wvalid, m0_axi_bready, m0_axi_arvalid, m0_axi_rready,
            s0_axi_awready, s0_axi_wready, s0_axi_bvalid, s0_axi_arready, s0_axi_rvalid,
            s1_axi_awready, s1_axi_wready, s1_axi_bvalid, s1_axi_arready, s1_axi_rvalid};
  endfunction

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    drive('0, '0, '0);
    m0_axi_bresp = 2'b00;
    axi_areset = 1'b1;
    #2;
    axi_areset = 1'b0;
  endtask

  int n, last_cyc, naw, nw, nb, s0b, aw_cyc, w_cyc;
  logic aw_l, w_l;

  initial begin
    drive('0, '0, '0);
    s0_axi_awaddr = 8'h04; s0_axi_wdata = 32'hDEADBEEF; s0_axi_wstrb = 4'hF; s0_axi_araddr = 8'h08;
    s1_axi_awaddr = 8'h30; s1_axi_wdata = 32'h11112222; s1_axi_wstrb = 4'h3; s1_axi_araddr = 8'h18;
    m0_axi_bresp = 2'b00; m0_axi_rresp = 2'b00; m0_axi_rdata = '0;
    axi_areset = 1'b1;

    // Reads from both masters after reset (s0 first, s1 second), then a single s0 write
    vecs[0]  = mkv('0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    vecs[1]  = mkv(5'b00010, 5'b00010, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    vecs[2]  = mkv(5'b00010, 5'b00010, 5'b00010, '0, 1'b1, 1'b0, 5'b00010, 5'b00010, '0,
                   '0, '0, '0, 8'h08, '0, '0);
    vecs[3]  = mkv(5'b00001, 5'b00010, 5'b00001, 32'hCAFEF00D, 1'b1, 1'b0, 5'b00001, 5'b00001, '0,
                   '0, '0, '0, '0, 32'hCAFEF00D, '0);
    vecs[4]  = mkv('0, 5'b00010, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    vecs[5]  = mkv('0, 5'b00010, 5'b00010, '0, 1'b1, 1'b1, 5'b00010, '0, 5'b00010,
                   '0, '0, '0, 8'h18, '0, '0);
    vecs[6]  = mkv('0, 5'b00001, 5'b00001, 32'h12345678, 1'b1, 1'b1, 5'b00001, '0, 5'b00001,
                   '0, '0, '0, '0, '0, 32'h12345678);
    vecs[7]  = mkv(5'b11000, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    vecs[8]  = mkv(5'b11000, '0, 5'b11000, '0, 1'b1, 1'b0, 5'b11000, 5'b11000, '0,
                   8'h04, 32'hDEADBEEF, 4'hF, '0, '0, '0);
    vecs[9]  = mkv(5'b00100, '0, 5'b00100, '0, 1'b1, 1'b0, 5'b00100, 5'b00100, '0,
                   '0, '0, '0, '0, '0, '0);
    vecs[10] = mkv('0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);

    #12;
    chk("reset_ctrl", 128'(ctrl_now()), 128'(0));
    chk("reset_payload", 128'({m0_axi_awaddr, m0_axi_wdata, m0_axi_araddr, s0_axi_rdata}), 128'(0));
    @(posedge axi_aclk);
    #1;
    axi_areset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].s0c, vecs[i].s1c, vecs[i].mc);
      m0_axi_rdata = vecs[i].mrdata;
      #1;
      chk($sformatf("vec%0d_ctrl", i), 128'(ctrl_now()),
          128'({vecs[i].busy, vecs[i].gid, vecs[i].m_o, vecs[i].s0_o, vecs[i].s1_o}));
      chk($sformatf("vec%0d_req_payload", i),
          128'({m0_axi_awaddr, m0_axi_wdata, m0_axi_wstrb, m0_axi_araddr}),
          128'({vecs[i].awaddr, vecs[i].wd, vecs[i].ws, vecs[i].araddr}));
      chk($sformatf("vec%0d_rdata", i), 128'({s0_axi_rdata, s1_axi_rdata}),
          128'({vecs[i].r0, vecs[i].r1}));
      tick();
    end

    // Fairness: both masters keep writing, grants must alternate every 3 cycles
    do_reset();
    drive(5'b11100, 5'b11100, 5'b11100);
    n = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
      #1;
      if (m0_axi_awvalid && m0_axi_awready) begin
        chk($sformatf("fair_grant%0d", n), 128'(grant_id), 128'(n % 2));
        if (n > 0) chk($sformatf("fair_gap%0d", n), 128'(cyc - last_cyc), 128'(3));
        last_cyc = cyc;
        n++;
      end
      tick();
    end
    chk("fair_count", 128'(n), 128'(8));

    // Split write: s1 shows W three cycles before AW, m0 awready held off two cycles
    do_reset();
    s1_axi_wdata = 32'hA1B2C3D4;
    s1_axi_wstrb = 4'hC;
    s1_axi_wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("split_wait%0d", i), 128'({busy, m0_axi_wvalid, s1_axi_wready}), 128'(0));
      tick();
    end
    s1_axi_awvalid = 1'b1;
    s1_axi_bready = 1'b1;
    m0_axi_wready = 1'b1;
    m0_axi_bresp = 2'b10;
    naw = 0; nw = 0; nb = 0; s0b = 0; aw_cyc = -1; w_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      m0_axi_awready = (i >= 3);
      m0_axi_bvalid = (i >= 4);
      #1;
      aw_l = m0_axi_awvalid & m0_axi_awready;
      w_l = m0_axi_wvalid & m0_axi_wready;
      if (aw_l) begin
        naw++; aw_cyc = i;
        chk("split_awaddr", 128'(m0_axi_awaddr), 128'(8'h30));
      end
      if (w_l) begin
        nw++; w_cyc = i;
        chk("split_wdata", 128'({m0_axi_wdata, m0_axi_wstrb}), 128'({32'hA1B2C3D4, 4'hC}));
      end
      if (s1_axi_bvalid && s1_axi_bready) begin
        nb++;
        chk("split_bresp", 128'({s1_axi_bresp, s0_axi_bresp}), 128'({2'b10, 2'b00}));
      end
      if (s0_axi_bvalid) s0b++;
      tick();
      if (aw_l) s1_axi_awvalid = 1'b0;
      if (w_l) s1_axi_wvalid = 1'b0;
    end
    chk("split_counts", 128'({8'(naw), 8'(nw), 8'(nb), 8'(s0b)}), 128'({8'd1, 8'd1, 8'd1, 8'd0}));
    chk("split_order", 128'({8'(w_cyc), 8'(aw_cyc)}), 128'({8'd1, 8'd3}));

    // Backpressure: rvalid held with s0 rready low; a second read stays pending
    do_reset();
    s0_axi_arvalid = 1'b1;
    m0_axi_arready = 1'b1;
    tick();
    #1;
    chk("bp_ar", 128'({m0_axi_arvalid, m0_axi_araddr}), 128'({1'b1, 8'h08}));
    tick();
    m0_axi_rvalid = 1'b1;
    m0_axi_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_hold%0d", i),
          128'({busy, s0_axi_rvalid, s0_axi_rdata, m0_axi_arvalid, m0_axi_rready}),
          128'({1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0}));
      tick();
    end
    s0_axi_rready = 1'b1;
    #1;
    chk("bp_release", 128'({s0_axi_rvalid, m0_axi_rready}), 128'({1'b1, 1'b1}));
    tick();
    chk("bp_idle", 128'(busy), 128'(0));
    drive('0, '0, '0);

    // Reset mid-write: asserted in WR_RESP, s1 still pending so only reset makes s0 win next
    do_reset();
    drive(5'b11000, 5'b11000, 5'b11000);
    tick();
    tick();
    s0_axi_awvalid = 1'b0;
    s0_axi_wvalid = 1'b0;
    s0_axi_bready = 1'b1;
    m0_axi_bvalid = 1'b1;
    #1;
    chk("rst_pre", 128'({busy, grant_id, s0_axi_bvalid, m0_axi_bready}), 128'(4'b1011));
    axi_areset = 1'b1;
    #1;
    chk("rst_async", 128'(ctrl_now()), 128'(0));
    @(negedge axi_aclk);
    axi_areset = 1'b0;
    m0_axi_bvalid = 1'b0;
    s0_axi_awvalid = 1'b1;
    s0_axi_wvalid = 1'b1;
    tick();
    chk("rst_next_grant", 128'({busy, grant_id, m0_axi_awaddr}), 128'({1'b1, 1'b0, 8'h04}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
